// File: rtl/posit_arith_pkg.sv
// Shared types and sizing helpers for leading-bit counting and posit regime decode.
package posit_arith_pkg;

  typedef enum logic {
    LOD_ONE = 1'b0,
    LOD_RUN = 1'b1
  } lod_mode_e;

  function automatic int cnt_width(input int word_size);
    return $clog2(word_size) + 1;
  endfunction

endpackage

// File: rtl/lead_count.sv
// Combinational leading-zero / regime-run counter over WORD_SIZE bits, found flag clear when no terminator.
// Pure logic, no latency; no handshake.
module lead_count
  import posit_arith_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0]       word_i,
  input  lod_mode_e                  mode_i,
  output logic [$clog2(WORD_SIZE):0] count_o,
  output logic                       vld_o
);

  localparam int LG = $clog2(WORD_SIZE);
  localparam int P  = 1 << LG;
  localparam int CW = cnt_width(WORD_SIZE);

  logic [WORD_SIZE-1:0] diff;
  logic [P-1:0]         padded;
  logic [P-1:0]         win;
  logic [LG-1:0]        half_cnt;

  // Run mode reduces to a zero count once bits equal to the MSB are flipped to 0.
  assign diff = word_i ^ {WORD_SIZE{(mode_i == LOD_RUN) & word_i[WORD_SIZE-1]}};

  generate
    if (P > WORD_SIZE) begin : g_pad
      // A 1 just below the real LSB stops the count at WORD_SIZE.
      localparam logic [P-1:0] STOP = P'(1) << (P - WORD_SIZE - 1);
      assign padded = {diff, {(P - WORD_SIZE){1'b0}}} | STOP;
    end else begin : g_nopad
      assign padded = diff;
    end
  endgenerate

  // Halving search: each level tests the top half of the remaining window.
  always_comb begin
    win      = padded;
    half_cnt = '0;
    for (int k = LG - 1; k >= 0; k--) begin
      if ((win >> (P - (1 << k))) == '0) begin
        half_cnt = half_cnt | LG'(1 << k);
        win      = win << (1 << k);
      end
    end
    vld_o   = |diff;
    count_o = vld_o ? {1'b0, half_cnt} : CW'(WORD_SIZE);
  end

endmodule

// File: rtl/lod_norm_pipe.sv
// Leading-one / regime-run count plus normalising left shift; LATENCY (1 or 2) cycles, valid/ready both sides,
// stages advance when empty or drained so bubbles collapse. Macro LOD_NORM_PIPE_TAG_EN adds a tag sideband.
module lod_norm_pipe
  import posit_arith_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int LATENCY   = 2
`ifdef LOD_NORM_PIPE_TAG_EN
  , parameter int TAG_W   = 4
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_mode,
  input  logic [WORD_SIZE-1:0]       in_word,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WORD_SIZE):0] out_count,
  output logic                       out_vld,
  output logic [WORD_SIZE-1:0]       out_norm
`ifdef LOD_NORM_PIPE_TAG_EN
  , input  logic [TAG_W-1:0]         in_tag,
  output logic [TAG_W-1:0]           out_tag
`endif
);

  localparam int CW = cnt_width(WORD_SIZE);

  logic [CW-1:0] lc_cnt;
  logic          lc_vld;
  logic          take;

  lead_count #(.WORD_SIZE(WORD_SIZE)) u_lead_count (
    .word_i  (in_word),
    .mode_i  (lod_mode_e'(in_mode)),
    .count_o (lc_cnt),
    .vld_o   (lc_vld)
  );

  assign take = in_valid & in_ready;

  generate
    if (LATENCY == 1) begin : g_lat1
      logic                 vld_q;
      logic [CW-1:0]        cnt_q;
      logic                 fnd_q;
      logic [WORD_SIZE-1:0] norm_q, norm_d;

      assign norm_d   = lc_vld ? (in_word << lc_cnt) : '0;
      assign in_ready = ~vld_q | out_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= 1'b0;
          cnt_q  <= '0;
          fnd_q  <= 1'b0;
          norm_q <= '0;
        end else begin
          if (in_ready) vld_q <= in_valid;
          if (take) begin
            cnt_q  <= lc_cnt;
            fnd_q  <= lc_vld;
            norm_q <= norm_d;
          end
        end
      end

      assign out_valid = vld_q;
      assign out_count = cnt_q;
      assign out_vld   = fnd_q;
      assign out_norm  = norm_q;

`ifdef LOD_NORM_PIPE_TAG_EN
      logic [TAG_W-1:0] tag_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       tag_q <= '0;
        else if (take) tag_q <= in_tag;
      end
      assign out_tag = tag_q;
`endif
    end else begin : g_lat2
      logic                 s1_vld_q, s2_vld_q;
      logic [CW-1:0]        s1_cnt_q, s2_cnt_q;
      logic                 s1_fnd_q, s2_fnd_q;
      logic [WORD_SIZE-1:0] s1_word_q;
      logic [WORD_SIZE-1:0] s2_norm_q, s2_norm_d;
      logic                 s2_adv;

      assign s2_adv    = ~s2_vld_q | out_ready;
      assign in_ready  = ~s1_vld_q | s2_adv;
      assign s2_norm_d = s1_fnd_q ? (s1_word_q << s1_cnt_q) : '0;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_vld_q  <= 1'b0;
          s1_cnt_q  <= '0;
          s1_fnd_q  <= 1'b0;
          s1_word_q <= '0;
          s2_vld_q  <= 1'b0;
          s2_cnt_q  <= '0;
          s2_fnd_q  <= 1'b0;
          s2_norm_q <= '0;
        end else begin
          if (in_ready) s1_vld_q <= in_valid;
          if (take) begin
            s1_cnt_q  <= lc_cnt;
            s1_fnd_q  <= lc_vld;
            s1_word_q <= in_word;
          end
          if (s2_adv) s2_vld_q <= s1_vld_q;
          if (s2_adv & s1_vld_q) begin
            s2_cnt_q  <= s1_cnt_q;
            s2_fnd_q  <= s1_fnd_q;
            s2_norm_q <= s2_norm_d;
          end
        end
      end

      assign out_valid = s2_vld_q;
      assign out_count = s2_cnt_q;
      assign out_vld   = s2_fnd_q;
      assign out_norm  = s2_norm_q;

`ifdef LOD_NORM_PIPE_TAG_EN
      logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_tag_q <= '0;
          s2_tag_q <= '0;
        end else begin
          if (take)              s1_tag_q <= in_tag;
          if (s2_adv & s1_vld_q) s2_tag_q <= s1_tag_q;
        end
      end
      assign out_tag = s2_tag_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_lod_norm_pipe.sv
// Bench for lod_norm_pipe: 8-bit LATENCY 2 and 1 instances plus a 12-bit LATENCY 2 instance,
// each scored against a bit-walking reference model on its own accepted words.
module tb_lod_norm_pipe;

  typedef struct {
    int          cnt;
    logic        fnd;
    logic [31:0] norm;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mode, out_ready;
  logic [7:0]  word8;
  logic [11:0] word12;
  logic [3:0]  tag_i;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [3:0]  out_count_a, out_count_b;
  logic [4:0]  out_count_c;
  logic        out_vld_a, out_vld_b, out_vld_c;
  logic [7:0]  out_norm_a, out_norm_b;
  logic [11:0] out_norm_c;
  logic [3:0]  otag_a, otag_b, otag_c;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   nout_a = 0, nout_b = 0, nout_c = 0;
  exp_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lod_norm_pipe #(.WORD_SIZE(8), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_mode(in_mode),
    .in_word(word8), .out_valid(out_valid_a), .out_ready(out_ready), .out_count(out_count_a),
    .out_vld(out_vld_a), .out_norm(out_norm_a)
`ifdef LOD_NORM_PIPE_TAG_EN
    , .in_tag(tag_i), .out_tag(otag_a)
`endif
  );

  lod_norm_pipe #(.WORD_SIZE(8), .LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_mode(in_mode),
    .in_word(word8), .out_valid(out_valid_b), .out_ready(out_ready), .out_count(out_count_b),
    .out_vld(out_vld_b), .out_norm(out_norm_b)
`ifdef LOD_NORM_PIPE_TAG_EN
    , .in_tag(tag_i), .out_tag(otag_b)
`endif
  );

  lod_norm_pipe #(.WORD_SIZE(12), .LATENCY(2)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_mode(in_mode),
    .in_word(word12), .out_valid(out_valid_c), .out_ready(out_ready), .out_count(out_count_c),
    .out_vld(out_vld_c), .out_norm(out_norm_c)
`ifdef LOD_NORM_PIPE_TAG_EN
    , .in_tag(tag_i), .out_tag(otag_c)
`endif
  );

`ifndef LOD_NORM_PIPE_TAG_EN
  assign otag_a = 4'h0;
  assign otag_b = 4'h0;
  assign otag_c = 4'h0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk down from the MSB while bits match the reference bit.
  function automatic exp_t ref_model(input int w, input logic [31:0] wd, input logic md,
                                     input logic [3:0] tg, input int acc);
    exp_t        e;
    logic        rb;
    logic [63:0] mask;
    rb    = md ? wd[w-1] : 1'b0;
    e.cnt = 0;
    while (e.cnt < w && wd[w-1-e.cnt] == rb) e.cnt++;
    e.fnd  = (e.cnt < w);
    mask   = (64'd1 << w) - 64'd1;
    e.norm = e.fnd ? 32'((64'(wd) << e.cnt) & mask) : 32'd0;
    e.tag  = tg;
    e.acc  = acc;
    return e;
  endfunction

  function automatic logic [31:0] rnd_w(input int w);
    logic [31:0] m, b;
    int          sh;
    m  = (32'd1 << w) - 32'd1;
    b  = $urandom & m;
    sh = $urandom_range(0, w);
    case ($urandom_range(0, 3))
      0:       return b;
      1:       return b >> sh;
      2:       return ~(b >> sh) & m;
      default: return ($urandom_range(0, 1) != 0) ? m : 32'd0;
    endcase
  endfunction

  task automatic mon(input string nm, input int w, input int lat, input logic rs, input logic iv,
                     input logic ir, input logic md, input logic [31:0] wd, input logic [3:0] tg,
                     input logic ov, input logic orr, input logic [31:0] oc, input logic of,
                     input logic [31:0] on, input logic [3:0] otg, ref exp_t q[$], ref int nout);
    exp_t e;
    if (rs) begin
      q.delete();
      return;
    end
    if (ov && q.size() == 0) begin
      chk($sformatf("%s_unexpected_out", nm), ov, 0);
    end else if (ov && orr) begin
      e = q.pop_front();
      chk($sformatf("%s_count", nm), oc, e.cnt);
      chk($sformatf("%s_vld", nm), of, e.fnd);
      chk($sformatf("%s_norm", nm), on, e.norm);
      chk($sformatf("%s_min_latency", nm), (cyc - e.acc) >= lat, 1);
`ifdef LOD_NORM_PIPE_TAG_EN
      chk($sformatf("%s_tag", nm), otg, e.tag);
`endif
      nout++;
    end else if (ov) begin
      chk($sformatf("%s_hold_norm", nm), on, q[0].norm);
    end
    if (iv && ir) q.push_back(ref_model(w, wd, md, tg, cyc));
  endtask

  always @(negedge clk) mon("a", 8, 2, rst, in_valid, in_ready_a, in_mode, 32'(word8), tag_i,
                            out_valid_a, out_ready, 32'(out_count_a), out_vld_a, 32'(out_norm_a),
                            otag_a, qa, nout_a);
  always @(negedge clk) mon("b", 8, 1, rst, in_valid, in_ready_b, in_mode, 32'(word8), tag_i,
                            out_valid_b, out_ready, 32'(out_count_b), out_vld_b, 32'(out_norm_b),
                            otag_b, qb, nout_b);
  always @(negedge clk) mon("c", 12, 2, rst, in_valid, in_ready_c, in_mode, 32'(word12), tag_i,
                            out_valid_c, out_ready, 32'(out_count_c), out_vld_c, 32'(out_norm_c),
                            otag_c, qc, nout_c);

  task automatic drain();
    int t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((qa.size() + qb.size() + qc.size()) != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_pending", qa.size() + qb.size() + qc.size(), 0);
    @(posedge clk); #1;
  endtask

  // One isolated word with out_ready high; A must show it exactly two cycles after the offer.
  task automatic send_dir(input string nm, input logic md, input logic [7:0] w8, input logic [11:0] w12,
                          input int ec, input logic ef, input logic [7:0] en,
                          input int ec12, input logic ef12, input logic [11:0] en12);
    in_valid = 1'b1;
    in_mode  = md;
    word8    = w8;
    word12   = w12;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready_a, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_a_early"}, out_valid_a, 0);
    chk({nm, "_b_valid"}, out_valid_b, 1);
    chk({nm, "_b_count"}, out_count_b, ec);
    chk({nm, "_b_norm"}, out_norm_b, en);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_a_valid"}, out_valid_a, 1);
    chk({nm, "_a_count"}, out_count_a, ec);
    chk({nm, "_a_vld"}, out_vld_a, ef);
    chk({nm, "_a_norm"}, out_norm_a, en);
    chk({nm, "_c_count"}, out_count_c, ec12);
    chk({nm, "_c_vld"}, out_vld_c, ef12);
    chk({nm, "_c_norm"}, out_norm_c, en12);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] sw[3];
    int         k, n0;
    logic       acc;

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
    word8 = '0; word12 = '0; tag_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid_a", out_valid_a, 0);
    chk("rst_out_valid_b", out_valid_b, 0);
    chk("rst_out_valid_c", out_valid_c, 0);
    chk("rst_count_a", out_count_a, 0);
    chk("rst_vld_a", out_vld_a, 0);
    chk("rst_norm_a", out_norm_a, 0);
    chk("rst_count_c", out_count_c, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready_a", in_ready_a, 1);
    chk("rst_in_ready_b", in_ready_b, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    send_dir("lod0",  1'b0, 8'h16, 12'h001, 3, 1'b1, 8'hB0, 11, 1'b1, 12'h800);
    send_dir("run_e5", 1'b1, 8'hE5, 12'hFFF, 3, 1'b1, 8'h28, 12, 1'b0, 12'h000);
    send_dir("run_ff", 1'b1, 8'hFF, 12'hE00, 8, 1'b0, 8'h00, 3, 1'b1, 12'h000);
    send_dir("lod_00", 1'b0, 8'h00, 12'h000, 8, 1'b0, 8'h00, 12, 1'b0, 12'h000);
    drain();

    // Stall: three words against a blocked output.
    sw[0] = 8'h16; sw[1] = 8'h80; sw[2] = 8'h01;
    out_ready = 1'b0; in_mode = 1'b0; in_valid = 1'b1; k = 0; word8 = sw[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready_a, i < 2);
      acc = in_ready_a;
      @(posedge clk); #1;
      if (acc && k < 2) begin
        k++;
        word8 = sw[k];
      end
    end
    n0 = nout_a;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && in_valid; i++) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    drain();
    chk("stall_out_count", nout_a - n0, 3);

    // Streaming: both latencies must produce a result every cycle once filled.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_mode = $urandom_range(0, 1);
      word8   = 8'(rnd_w(8));
      word12  = 12'(rnd_w(12));
      @(negedge clk);
      chk("stream_in_ready_a", in_ready_a, 1);
      if (i >= 2) chk("stream_valid_a", out_valid_a, 1);
      if (i >= 1) chk("stream_valid_b", out_valid_b, 1);
      @(posedge clk); #1;
    end
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0; in_mode = 1'b0; in_valid = 1'b1;
    tag_i = 4'hA; word8 = 8'h16;
    @(posedge clk); #1;
    tag_i = 4'h5; word8 = 8'h03;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid_a", out_valid_a, 0);
    chk("midrst_valid_b", out_valid_b, 0);
    chk("midrst_valid_c", out_valid_c, 0);
    chk("midrst_norm_a", out_norm_a, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stale_a", out_valid_a, 0);
      chk("stale_b", out_valid_b, 0);
      chk("postrst_in_ready_a", in_ready_a, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; tag_i = 4'hA; word8 = 8'h16;
    @(posedge clk); #1;
    tag_i = 4'h5; word8 = 8'h03;
    @(posedge clk); #1;
    drain();

    // Randomized traffic with random backpressure and per-word mode changes.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = $urandom_range(0, 1);
      word8     = 8'(rnd_w(8));
      word12    = 12'(rnd_w(12));
      tag_i     = 4'($urandom);
      @(posedge clk); #1;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
